// File: rtl/game_pkg.sv
// Shared state encodings, parameter defaults and round-robin helper for the
// Space Invaders play-flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT = 3'd0,
    ST_PLAY    = 3'd1,
    ST_HIT     = 3'd2,
    ST_RESPAWN = 3'd3,
    ST_WIN     = 3'd4,
    ST_OVER    = 3'd5
  } game_state_e;

  localparam int unsigned NUM_ALIENS       = 3;
  localparam int unsigned DEF_START_LIVES  = 3;
  localparam int unsigned DEF_HIT_FRAMES   = 60;
  localparam int unsigned DEF_FIRE_PERIOD  = 45;

  // Next alien index modulo NUM_ALIENS; an out-of-range index wraps to 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'(NUM_ALIENS - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/fire_rr_picker.sv
// Combinational round-robin selector: first living alien after ptr, with wrap.
module fire_rr_picker
  import game_pkg::*;
(
  input  logic [2:0] alive,
  input  logic [1:0] ptr,
  output logic [2:0] grant,
  output logic       valid,
  output logic [1:0] next_ptr
);

  logic [1:0] idx;

  always_comb begin
    grant    = '0;
    valid    = 1'b0;
    next_ptr = ptr;
    idx      = ptr;
    for (int unsigned k = 0; k < NUM_ALIENS; k++) begin
      idx = rr_next(idx);
      if (!valid && alive[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
        next_ptr   = idx;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Play-flow controller: sequences the spaceship mode, tracks lives, detects
// win/loss and schedules round-robin alien shots once per fire period.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned START_LIVES = DEF_START_LIVES,
  parameter int unsigned HIT_FRAMES  = DEF_HIT_FRAMES,
  parameter int unsigned FIRE_PERIOD = DEF_FIRE_PERIOD
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       button_start,
  input  logic [9:0] xCoord,
  input  logic [9:0] yCoord,
  input  logic       ship_can_move,
  input  logic [2:0] alien_alive,
  input  logic       aliens_landed,
  output logic       mode,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic [2:0] alien_fire,
  output logic       game_over,
  output logic       game_won
);

  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] FIRE_LAST  = 8'(FIRE_PERIOD - 1);

  game_state_e state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic        mode_q, mode_d;
  logic [2:0]  fire_q, fire_d;
  logic        over_q, over_d;
  logic        won_q, won_d;
  logic [7:0]  hit_cnt_q, hit_cnt_d;
  logic [7:0]  fire_cnt_q, fire_cnt_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;

  logic start_q, start_qq, ship_q, ship_qq, origin_q;
  logic origin, frame_tick, start_rise, ship_hit, fire_due;

  logic [2:0] pick_grant;
  logic       pick_valid;
  logic [1:0] pick_ptr;

  assign origin     = (xCoord == 10'd0) && (yCoord == 10'd0);
  assign frame_tick = origin && !origin_q;
  assign start_rise = start_q && !start_qq;
  assign ship_hit   = !ship_q && ship_qq;
  assign fire_due   = (state_q == ST_PLAY) && frame_tick && (fire_cnt_q == FIRE_LAST);

  fire_rr_picker u_picker (
    .alive    (alien_alive),
    .ptr      (rr_ptr_q),
    .grant    (pick_grant),
    .valid    (pick_valid),
    .next_ptr (pick_ptr)
  );

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    hit_cnt_d  = hit_cnt_q;
    fire_cnt_d = fire_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    fire_d     = '0;

    case (state_q)
      ST_ATTRACT: if (start_rise) state_d = ST_PLAY;
      ST_PLAY: begin
        if (frame_tick) fire_cnt_d = fire_due ? '0 : fire_cnt_q + 8'd1;
        // The shot is issued even when the same clk also leaves PLAY.
        if (fire_due && pick_valid) begin
          fire_d   = pick_grant;
          rr_ptr_d = pick_ptr;
        end
        if (aliens_landed) begin
          state_d = ST_OVER;
        end else if (ship_hit) begin
          state_d = ST_HIT;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        end else if (alien_alive == '0) begin
          state_d = ST_WIN;
        end
      end
      ST_HIT: begin
        if (frame_tick) begin
          if (hit_cnt_q == HIT_LAST) begin
            hit_cnt_d = '0;
            state_d   = (lives_q == 2'd0) ? ST_OVER : ST_RESPAWN;
          end else begin
            hit_cnt_d = hit_cnt_q + 8'd1;
          end
        end
      end
      ST_RESPAWN: state_d = ST_PLAY;
      ST_WIN, ST_OVER: if (start_rise) state_d = ST_ATTRACT;
      default: state_d = ST_ATTRACT;
    endcase

    if (state_d == ST_PLAY && state_q != ST_PLAY) fire_cnt_d = '0;
    if (state_d == ST_HIT && state_q != ST_HIT) hit_cnt_d = '0;
    if (state_d == ST_ATTRACT) lives_d = LIVES_INIT;

    mode_d = (state_d == ST_PLAY) || (state_d == ST_HIT) ||
             (state_d == ST_WIN)  || (state_d == ST_OVER);
    over_d = (state_d == ST_OVER);
    won_d  = (state_d == ST_WIN);
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q    <= ST_ATTRACT;
      lives_q    <= LIVES_INIT;
      mode_q     <= 1'b0;
      fire_q     <= '0;
      over_q     <= 1'b0;
      won_q      <= 1'b0;
      hit_cnt_q  <= '0;
      fire_cnt_q <= '0;
      rr_ptr_q   <= 2'd2;
      start_q    <= 1'b0;
      start_qq   <= 1'b0;
      ship_q     <= 1'b0;
      ship_qq    <= 1'b0;
      origin_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      mode_q     <= mode_d;
      fire_q     <= fire_d;
      over_q     <= over_d;
      won_q      <= won_d;
      hit_cnt_q  <= hit_cnt_d;
      fire_cnt_q <= fire_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      start_q    <= button_start;
      start_qq   <= start_q;
      ship_q     <= ship_can_move;
      ship_qq    <= ship_q;
      origin_q   <= origin;
    end
  end

  assign state      = state_q;
  assign lives      = lives_q;
  assign mode       = mode_q;
  assign alien_fire = fire_q;
  assign game_over  = over_q;
  assign game_won   = won_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: start, hits, respawn, loss, win,
// round-robin firing and restart priority.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       restart;
  logic       button_start;
  logic [9:0] xCoord;
  logic [9:0] yCoord;
  logic       ship_can_move;
  logic [2:0] alien_alive;
  logic       aliens_landed;
  logic       mode;
  logic [1:0] lives;
  logic [2:0] state;
  logic [2:0] alien_fire;
  logic       game_over;
  logic       game_won;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_sequencer #(
    .START_LIVES (3),
    .HIT_FRAMES  (60),
    .FIRE_PERIOD (2)
  ) dut (
    .clk           (clk),
    .restart       (restart),
    .button_start  (button_start),
    .xCoord        (xCoord),
    .yCoord        (yCoord),
    .ship_can_move (ship_can_move),
    .alien_alive   (alien_alive),
    .aliens_landed (aliens_landed),
    .mode          (mode),
    .lives         (lives),
    .state         (state),
    .alien_fire    (alien_fire),
    .game_over     (game_over),
    .game_won      (game_won)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: origin for one clk (produces one tick), then elsewhere.
  task automatic frame();
    xCoord = 10'd0;
    yCoord = 10'd0;
    step();
    xCoord = 10'd5;
    yCoord = 10'd5;
    step();
  endtask

  task automatic press_start();
    button_start = 1'b1;
    step();
    step();
    button_start = 1'b0;
    step();
  endtask

  task automatic hit(input logic [1:0] exp_lives);
    ship_can_move = 1'b0;
    step();
    check("hit_lat1_state", state, 3'd1);
    step();
    check("hit_state", state, 3'd2);
    check("hit_lives", lives, exp_lives);
    ship_can_move = 1'b1;
  endtask

  logic [2:0] fire_exp [3];

  initial begin
    restart       = 1'b1;
    button_start  = 1'b0;
    xCoord        = 10'd5;
    yCoord        = 10'd5;
    ship_can_move = 1'b1;
    alien_alive   = 3'b111;
    aliens_landed = 1'b0;
    fire_exp[0]   = 3'b001;
    fire_exp[1]   = 3'b100;
    fire_exp[2]   = 3'b001;
    step();
    step();
    check("rst_state", state, 3'd0);
    check("rst_mode", mode, 1'b0);
    check("rst_lives", lives, 2'd3);
    check("rst_fire", alien_fire, 3'b000);
    check("rst_over", game_over, 1'b0);
    check("rst_won", game_won, 1'b0);
    restart = 1'b0;
    step();

    // Start: mode rises two clk after the button rise.
    button_start = 1'b1;
    step();
    check("start_lat1_mode", mode, 1'b0);
    step();
    check("start_mode", mode, 1'b1);
    check("start_state", state, 3'd1);
    check("start_lives", lives, 2'd3);
    button_start = 1'b0;
    step();

    // First hit, full pause, one-clk respawn.
    hit(2'd2);
    repeat (59) frame();
    check("hit59_state", state, 3'd2);
    xCoord = 10'd0;
    yCoord = 10'd0;
    step();
    check("respawn_state", state, 3'd3);
    check("respawn_mode", mode, 1'b0);
    xCoord = 10'd5;
    yCoord = 10'd5;
    step();
    check("replay_state", state, 3'd1);
    check("replay_mode", mode, 1'b1);

    // Round-robin fire every second tick with aliens 0 and 2 alive.
    alien_alive = 3'b101;
    for (int i = 0; i < 3; i++) begin
      frame();
      check("fire_idle", alien_fire, 3'b000);
      xCoord = 10'd0;
      yCoord = 10'd0;
      step();
      check("fire_pulse", alien_fire, fire_exp[i]);
      xCoord = 10'd5;
      yCoord = 10'd5;
      step();
      check("fire_width", alien_fire, 3'b000);
    end

    // Second and third hits: last one ends in OVER with no respawn.
    hit(2'd1);
    repeat (60) frame();
    check("hit2_back_state", state, 3'd1);
    hit(2'd0);
    repeat (59) frame();
    xCoord = 10'd0;
    yCoord = 10'd0;
    step();
    check("over_state", state, 3'd5);
    check("over_flag", game_over, 1'b1);
    check("over_mode", mode, 1'b1);
    xCoord = 10'd5;
    yCoord = 10'd5;
    step();
    check("over_hold", state, 3'd5);
    button_start = 1'b1;
    step();
    step();
    check("newgame_state", state, 3'd0);
    check("newgame_lives", lives, 2'd3);
    check("newgame_over", game_over, 1'b0);
    check("newgame_mode", mode, 1'b0);
    button_start = 1'b0;
    step();

    // Landed and ship hit in the same clk: landed wins, lives kept.
    press_start();
    check("landed_pre_state", state, 3'd1);
    ship_can_move = 1'b0;
    step();
    aliens_landed = 1'b1;
    step();
    check("landed_state", state, 3'd5);
    check("landed_lives", lives, 2'd3);
    aliens_landed = 1'b0;
    ship_can_move = 1'b1;
    step();

    // All aliens dead -> WIN.
    press_start();
    press_start();
    alien_alive = 3'b000;
    step();
    check("win_state", state, 3'd4);
    check("win_flag", game_won, 1'b1);
    check("win_mode", mode, 1'b1);
    alien_alive = 3'b111;

    // Restart mid-HIT after 30 ticks.
    press_start();
    press_start();
    hit(2'd2);
    repeat (30) frame();
    check("midhit_state", state, 3'd2);
    restart = 1'b1;
    step();
    check("rst_hit_state", state, 3'd0);
    check("rst_hit_mode", mode, 1'b0);
    check("rst_hit_lives", lives, 2'd3);
    check("rst_hit_fire", alien_fire, 3'b000);
    restart = 1'b0;
    step();

    // Restart on the clk a fire pulse would be issued.
    press_start();
    alien_alive = 3'b101;
    frame();
    xCoord  = 10'd0;
    yCoord  = 10'd0;
    restart = 1'b1;
    step();
    check("rst_fire_pulse", alien_fire, 3'b000);
    check("rst_fire_state", state, 3'd0);
    restart = 1'b0;
    xCoord  = 10'd5;
    yCoord  = 10'd5;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
